// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared BCD counter types, constants and digit saturation
package counter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    // Clamp an arbitrary nibble to a legal decimal digit.
    function automatic bcd_t sat_nine(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : bcd_t'(v);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one decade of the BCD down counter with borrow ripple
module bcd_down_digit
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] din,
    input  logic       bin,
    output logic [3:0] dq,
    output logic       bout_d
);

    bcd_t digit;

    // Load a saturated preset, or step down one decade position when borrowed into.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            digit <= '0;
        end else if (load) begin
            digit <= sat_nine(din);
        end else if (bin) begin
            digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign dq     = digit;
    assign bout_d = bin & (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD down counter with load, wrap/one-shot and terminal count
module bcd_down_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] d,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    zero,
    output logic                    tc,
    output logic                    bout
);

    logic [DIGITS:0] borrow;
    logic            step_ok;
    logic            at_one;

    // In one-shot mode the all-zero state must not step, otherwise every digit would roll to nine.
    assign step_ok   = (WRAP != 0) | ~zero;
    assign borrow[0] = en & ~load & step_ok;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_down_digit u_digit (
                .clk    (clk),
                .clr    (clr),
                .load   (load),
                .din    (d[BCD_W*i +: BCD_W]),
                .bin    (borrow[i]),
                .dq     (q[BCD_W*i +: BCD_W]),
                .bout_d (borrow[i+1])
            );
        end
    endgenerate

    assign zero   = (q == '0);
    assign at_one = (q == (BCD_W*DIGITS)'(1));

    // The end-of-chain borrow only fires when the whole count is zero, so it folds into the zero term.
    assign bout = (en & zero & ~load) | borrow[DIGITS];

    // Single-cycle pulse on the enabled step that takes the count from one to zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tc <= 1'b0;
        end else begin
            tc <= en & ~load & at_one;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - scoreboard bench for bcd_down_counter with an integer reference model
module tb_bcd_down_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = 8'h00;

    logic [7:0] q_a, q_b;
    logic       zero_a, tc_a, bout_a;
    logic       zero_b, tc_b, bout_b;
    logic [3:0] q_lo, q_hi;
    logic       zero_lo, tc_lo, bout_lo;
    logic       zero_hi, tc_hi, bout_hi;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int va;
        bit tca;
        int vb;
        bit tcb;
        bit tclo;
        bit tchi;
    } exp_t;

    exp_t exp_q[$];

    int va = 0;
    int vb = 0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_a), .zero(zero_a), .tc(tc_a), .bout(bout_a)
    );

    bcd_down_counter #(.DIGITS(2), .WRAP(0)) u_oneshot (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_b), .zero(zero_b), .tc(tc_b), .bout(bout_b)
    );

    bcd_down_counter #(.DIGITS(1), .WRAP(1)) u_lo (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d[3:0]),
        .q(q_lo), .zero(zero_lo), .tc(tc_lo), .bout(bout_lo)
    );

    bcd_down_counter #(.DIGITS(1), .WRAP(1)) u_hi (
        .clk(clk), .clr(clr), .en(bout_lo), .load(load), .d(d[7:4]),
        .q(q_hi), .zero(zero_hi), .tc(tc_hi), .bout(bout_hi)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int preset_val(input logic [7:0] dv);
        int hi, lo;
        hi = int'(dv[7:4]);
        lo = int'(dv[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic int next_val(input int v, input bit e, input bit l,
                                    input logic [7:0] dv, input bit wrap);
        if (l) return preset_val(dv);
        if (!e) return v;
        if (v > 0) return v - 1;
        return wrap ? 99 : 0;
    endfunction

    // One stimulus cycle: drive at the falling edge, check combinational outputs, queue the edge result.
    task automatic step(input bit c, input bit e, input bit l, input logic [7:0] dv);
        exp_t x;
        @(negedge clk);
        clr = c; en = e; load = l; d = dv;
        if (c) begin
            va = 0;
            vb = 0;
        end
        #1;
        if (c) begin
            chk("async_clr_q", int'(q_a), 0);
            chk("async_clr_tc", int'(tc_a), 0);
        end
        chk("zero_a", int'(zero_a), int'(va == 0));
        chk("bout_a", int'(bout_a), int'(e & ~l & (va == 0)));
        chk("zero_b", int'(zero_b), int'(vb == 0));
        chk("bout_b", int'(bout_b), int'(e & ~l & (vb == 0)));
        chk("bout_lo", int'(bout_lo), int'(e & ~l & ((va % 10) == 0)));
        if (c) begin
            x.va = 0; x.tca = 1'b0; x.vb = 0; x.tcb = 1'b0;
            x.tclo = 1'b0; x.tchi = 1'b0;
        end else begin
            x.tca  = e & ~l & (va == 1);
            x.tcb  = e & ~l & (vb == 1);
            x.tclo = e & ~l & ((va % 10) == 1);
            x.tchi = e & ~l & (va == 10);
            va = next_val(va, e, l, dv, 1'b1);
            vb = next_val(vb, e, l, dv, 1'b0);
            x.va = va;
            x.vb = vb;
        end
        exp_q.push_back(x);
    endtask

    // Monitor: after every rising edge, compare the registered outputs with the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("q_wrap", int'(q_a), to_bcd(x.va));
                chk("tc_wrap", int'(tc_a), int'(x.tca));
                chk("q_oneshot", int'(q_b), to_bcd(x.vb));
                chk("tc_oneshot", int'(tc_b), int'(x.tcb));
                chk("q_cascade", int'({q_hi, q_lo}), to_bcd(x.va));
                chk("tc_lo", int'(tc_lo), int'(x.tclo));
                chk("tc_hi", int'(tc_hi), int'(x.tchi));
            end
        end
    end

    initial begin
        bit c, e, l;
        step(1, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);

        // Borrow across digits, terminal count and wrap to 99.
        step(0, 0, 1, 8'h12);
        for (int i = 0; i < 13; i++) step(0, 1, 0, 8'h00);

        // One-shot expiry from 03.
        step(0, 0, 1, 8'h03);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);

        // Load beats enable, digits saturate, load of zero clears the pulse.
        step(0, 1, 1, 8'hF5);
        step(0, 1, 1, 8'h9C);
        step(0, 0, 1, 8'h01);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Cascade boundary 20 -> 19, and a hold cycle.
        step(0, 0, 1, 8'h20);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // Asynchronous clear mid-count, held with enable high.
        step(0, 0, 1, 8'h37);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);

        for (int i = 0; i < 500; i++) begin
            c = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(c, e, l, 8'($urandom_range(0, 255)));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
